// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: fetches one 16-bit word per request from a
// synchronous program memory, splits it into four nibble fields and holds them for the consumer.
module instr_fetch_decode #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    output logic                 mem_rd,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    input  logic                 jump,
    input  logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [3:0]           op_code,
    output logic [3:0]           mem_op,
    output logic [3:0]           left_op,
    output logic [3:0]           right_op,
    output logic [ADDR_SIZE-1:0] pc_out,
    output logic                 wrap,
    output logic [1:0]           dbg_state
);

    // Handshake: the decoded word transfers on a cycle where dec_valid && dec_ready
    // and jump is low; dec_valid never drops without a transfer unless jump redirects.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t               state_q;
    logic [ADDR_SIZE-1:0] pc_q;
    logic [ADDR_SIZE-1:0] pc_d;
    logic [ADDR_SIZE-1:0] pc_out_q;
    logic [15:0]          word_q;
    logic                 mem_rd_q;
    logic                 dec_valid_q;
    logic                 wrap_q;
    logic                 discard_q;
    state_t               exit_state_d;

    always_comb begin
        pc_d         = pc_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        exit_state_d = en ? ST_REQ : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            pc_out_q    <= '0;
            word_q      <= '0;
            mem_rd_q    <= 1'b0;
            dec_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            // A redirect always wins; the WAIT increment below only runs without one.
            if (jump) begin
                pc_q <= jump_addr;
            end
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q  <= ST_REQ;
                        mem_rd_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q   <= ST_WAIT;
                    mem_rd_q  <= 1'b0;
                    discard_q <= jump;
                end
                ST_WAIT: begin
                    discard_q <= 1'b0;
                    // The returning word belongs to a stale pc if a jump hit REQ or WAIT.
                    if (jump || discard_q) begin
                        state_q  <= exit_state_d;
                        mem_rd_q <= en;
                    end else begin
                        word_q      <= mem_rdata[15:0];
                        pc_out_q    <= pc_q;
                        pc_q        <= pc_d;
                        wrap_q      <= (pc_q == '1);
                        dec_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (jump || dec_ready) begin
                        dec_valid_q <= 1'b0;
                        state_q     <= exit_state_d;
                        mem_rd_q    <= en;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = pc_q;
    assign dec_valid = dec_valid_q;
    assign op_code   = word_q[15:12];
    assign mem_op    = word_q[11:8];
    assign left_op   = word_q[7:4];
    assign right_op  = word_q[3:0];
    assign pc_out    = pc_out_q;
    assign wrap      = wrap_q;
    assign dbg_state = state_q;

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16: program memory word width; fixed at 16 for field decode.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 5: program memory address width; 32 words.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: fetch enable; sampled at the IDLE and HOLD exits.
REQ-006 The block SHALL have port mem_rd, output, 1 bit: program memory read strobe.
REQ-007 The block SHALL have port mem_addr, output, ADDR_SIZE bits: program memory read address.
REQ-008 The block SHALL have port mem_rdata, input, DATA_SIZE bits: read data, valid exactly one cycle after mem_rd.
REQ-009 The block SHALL have port jump, input, 1 bit: PC redirect request.
REQ-010 The block SHALL have port jump_addr, input, ADDR_SIZE bits: PC redirect target.
REQ-011 The block SHALL have port dec_valid, output, 1 bit: decoded instruction available.
REQ-012 The block SHALL have port dec_ready, input, 1 bit: consumer accepts the decoded instruction.
REQ-013 The block SHALL have port op_code, output, 4 bits: word bits [15:12].
REQ-014 The block SHALL have port mem_op, output, 4 bits: word bits [11:8].
REQ-015 The block SHALL have port left_op, output, 4 bits: word bits [7:4].
REQ-016 The block SHALL have port right_op, output, 4 bits: word bits [3:0].
REQ-017 The block SHALL have port pc_out, output, ADDR_SIZE bits: address of the instruction currently presented.
REQ-018 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the PC increments from 2^ADDR_SIZE-1 to 0.

Function
REQ-019 The block SHALL implement a 4-state FSM with states IDLE, REQ, WAIT and HOLD.
REQ-020 In IDLE the block SHALL hold mem_rd=0 and go to REQ when en=1.
REQ-021 In REQ the block SHALL assert mem_rd=1 with mem_addr=pc for exactly one cycle, then go to WAIT.
REQ-022 In WAIT the block SHALL register mem_rdata into the output fields, set pc_out=pc, set pc=pc+1 modulo 2^ADDR_SIZE, set dec_valid=1 from the next cycle, and go to HOLD.
REQ-023 In HOLD the block SHALL keep dec_valid and all decoded fields stable until dec_valid&&dec_ready.
REQ-024 On HOLD acceptance the block SHALL clear dec_valid and go to REQ if en=1, otherwise to IDLE.
REQ-025 Throughput SHALL be at most one instruction per 3 cycles; latency from REQ entry to dec_valid SHALL be 2 cycles.
REQ-026 mem_addr SHALL equal pc in every state; mem_rd SHALL be 1 only in REQ.
REQ-027 The block SHALL pulse wrap for one cycle in the cycle after the WAIT increment takes pc from 31 to 0.
REQ-028 jump=1 in any state SHALL load pc<=jump_addr and take priority over the WAIT increment.
REQ-029 jump=1 in WAIT SHALL discard the returning word: no dec_valid, fields unchanged, next state REQ if en=1, otherwise IDLE.
REQ-030 jump=1 in HOLD SHALL drop dec_valid the next cycle regardless of dec_ready, with next state REQ if en=1, otherwise IDLE.
REQ-031 jump=1 in IDLE or REQ SHALL only redirect pc; a REQ read in flight continues to WAIT and is discarded per REQ-029.
REQ-032 Deasserting en SHALL NOT abort a fetch in progress; it SHALL take effect only at the IDLE and HOLD exits.

Reset
REQ-033 On rstn=0 the block SHALL immediately, asynchronously, set state=IDLE, pc=0, mem_rd=0, mem_addr=0, dec_valid=0, op_code/mem_op/left_op/right_op=0, pc_out=0 and wrap=0.
REQ-034 Reset asserted mid-fetch SHALL discard any in-flight word; after release the block SHALL fetch from address 0.

Verification
REQ-035 Memory[0]=16'hX012 (op_code X, mem_op 0, left 1, right 2), en=1, dec_ready=1 -> mem_rd at address 0, dec_valid 2 cycles later with op_code=X, mem_op=0, left_op=1, right_op=2, pc_out=0.
REQ-036 dec_ready=0 for 5 cycles while in HOLD -> fields and pc_out stable and mem_rd=0 throughout; a single acceptance follows, then a fetch from address 1.
REQ-037 Run 33 fetches from address 0 -> wrap pulses exactly once, after the fetch of address 31, and the next fetch address is 0.
REQ-038 jump=1 with jump_addr=7 asserted during WAIT -> no dec_valid for that word; the next mem_rd uses address 7.
REQ-039 jump=1 with jump_addr=3 in HOLD, with dec_ready=1 in the same cycle -> dec_valid drops, no acceptance is counted, and the next fetch is from address 3.
REQ-040 rstn pulsed low during WAIT -> all outputs are 0 immediately; after release with en=1 the first mem_addr is 0.
